prog_sequencer: RTL and testbench
=================================

// Module: prog_sequencer
// PURPOSE
//  Multi-cycle program sequencer for the 9-bit core. Owns the program counter and run/halt FSM.
//  Consumes decoder strobes (ConditionalJump, BranchAbsOrRel, LoadInst, Ack) and the branch-condition
//  result. Drives the instruction-ROM address and gates reg-file/data-mem writes during load stalls.
// PARAMETERS
//  PC_W        10  program counter / instr ROM address width
//  OFF_W       8   signed relative-branch offset width
//  START_ADDR  0   PC value on reset and on every accepted Start
//  LOAD_STALL  1   extra cycles a load occupies (0..7); 0 = single-cycle load
// PORTS
//  Clk            in   1      clock, all state on rising edge
//  Reset          in   1      synchronous, active-high
//  Start          in   1      begin program; sampled in IDLE and HALT only
//  Ack            in   1      decoder: halt instruction in current slot
//  ConditionalJump in  1      decoder: branch instruction
//  BranchAbsOrRel in   1      decoder: 0 = absolute target, 1 = relative offset
//  BranchTaken    in   1      ALU/flag condition met for current branch
//  LoadInst       in   1      decoder: data-memory load
//  BranchTarget   in   PC_W   absolute target (from LUT)
//  BranchOffset   in   OFF_W  signed two's-complement relative offset
//  ProgCtr        out  PC_W   instruction ROM address
//  WrGate         out  1      qualifies RegWrEn/MemWrEn; write only when 1
//  Busy           out  1      state is RUN or LWAIT
//  Done           out  1      state is HALT
// BEHAVIOUR
//  States: IDLE, RUN, LWAIT, HALT. Reset (any state, any cycle) -> IDLE, ProgCtr=START_ADDR,
//   stall count=0, WrGate=0, Busy=0, Done=0. Reset overrides all other inputs same edge.
//  IDLE: ProgCtr held. Start=1 -> RUN next cycle; ProgCtr stays START_ADDR (first fetch there).
//  RUN, priority per cycle: Ack > LoadInst (LOAD_STALL>0) > taken branch > sequential.
//   Ack=1: -> HALT; ProgCtr held on halt instr; WrGate=0 this cycle.
//   LoadInst=1, LOAD_STALL>0: WrGate=0; -> LWAIT with count=LOAD_STALL-1; ProgCtr held.
//   ConditionalJump & BranchTaken: ProgCtr <= BranchAbsOrRel ? ProgCtr+sext(BranchOffset) : BranchTarget.
//   Otherwise ProgCtr <= ProgCtr+1. All PC arithmetic modulo 2^PC_W (wraps, no error).
//   WrGate=1 in RUN except cases above.
//  LWAIT: ProgCtr held, instruction still presented. count>0: count--, WrGate=0.
//   count==0: WrGate=1 (load writes now), ProgCtr <= ProgCtr+1, -> RUN.
//   Load occupies exactly LOAD_STALL+1 cycles; decoder inputs other than LoadInst ignored in LWAIT.
//  LOAD_STALL=0: LWAIT unreachable; load completes in one RUN cycle with WrGate=1.
//  HALT: ProgCtr held, Done=1, WrGate=0. Start=1 -> RUN, ProgCtr<=START_ADDR (restart).
//  Start in RUN/LWAIT ignored. Busy/Done/WrGate are decodes of current state (combinational).
// CONFIGURATION
//  SEQ_CYCLE_COUNT_EN defined: adds output CycleCount [31:0]; cleared by Reset and on Start
//   acceptance; +1 each cycle in RUN or LWAIT; held in IDLE/HALT; saturates at 32'hFFFF_FFFF.
//  Undefined: CycleCount port and counter absent; all other behaviour identical.
// TESTING
//  Reset, Start, 5 plain instrs, then Ack -> ProgCtr 0,1,2,3,4,5 held; Done=1 from cycle after Ack.
//  Branch at PC=3, abs, taken, Target=40 -> next ProgCtr=40; not taken -> 4.
//  Relative branch at PC=2, Offset=-3 (8'hFD), taken -> ProgCtr=1023 (wrap, PC_W=10).
//  LOAD_STALL=2, load at PC=7 -> ProgCtr 7 for 3 cycles, WrGate 0,0,1, then ProgCtr=8.
//  Reset asserted in LWAIT -> next cycle IDLE, ProgCtr=0, WrGate=0; Ack+Branch same cycle -> HALT.
//  SEQ_CYCLE_COUNT_EN: 5 instrs + 1-stall load then Ack -> CycleCount=8; Start in HALT clears to 0.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer for the 9-bit core: program counter plus IDLE/RUN/LWAIT/HALT control.
// Optional SEQ_CYCLE_COUNT_EN adds a saturating CycleCount output for RUN/LWAIT cycles.
module prog_sequencer #(
   parameter int PC_W       = 10,
   parameter int OFF_W      = 8,
   parameter int START_ADDR = 0,
   parameter int LOAD_STALL = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Ack,
   input  logic             ConditionalJump,
   input  logic             BranchAbsOrRel,
   input  logic             BranchTaken,
   input  logic             LoadInst,
   input  logic [PC_W-1:0]  BranchTarget,
   input  logic [OFF_W-1:0] BranchOffset,
   output logic [PC_W-1:0]  ProgCtr,
   output logic             WrGate,
   output logic             Busy,
   output logic             Done
`ifdef SEQ_CYCLE_COUNT_EN
   ,
   output logic [31:0]      CycleCount
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, LWAIT, HALT} state_t;

   localparam logic [PC_W-1:0] START_PC   = PC_W'(START_ADDR);
   localparam bit              HAS_STALL  = (LOAD_STALL > 0);
   localparam logic [2:0]      STALL_INIT = HAS_STALL ? 3'(LOAD_STALL - 1) : 3'd0;

   state_t          state;
   logic [2:0]      stall_cnt;
   logic [PC_W-1:0] off_ext;

   // Relative offsets are two's complement; sign-extend before the modulo-2^PC_W add.
   assign off_ext = PC_W'($signed(BranchOffset));

   // NOTE: all state updates use <= so every register samples pre-edge values of the others.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         ProgCtr   <= START_PC;
         stall_cnt <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  state   <= RUN;
                  ProgCtr <= START_PC;
               end
            end
            RUN: begin
               if (Ack) begin
                  state <= HALT;
               end else if (LoadInst && HAS_STALL) begin
                  state     <= LWAIT;
                  stall_cnt <= STALL_INIT;
               end else if (ConditionalJump && BranchTaken) begin
                  ProgCtr <= BranchAbsOrRel ? ProgCtr + off_ext : BranchTarget;
               end else begin
                  ProgCtr <= ProgCtr + 1'b1;
               end
            end
            LWAIT: begin
               // Decoder strobes are ignored here; the load instruction stays on the bus.
               if (stall_cnt != 3'd0) begin
                  stall_cnt <= stall_cnt - 3'd1;
               end else begin
                  state   <= RUN;
                  ProgCtr <= ProgCtr + 1'b1;
               end
            end
            HALT: begin
               if (Start) begin
                  state   <= RUN;
                  ProgCtr <= START_PC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: WrGate defaults to 0 before the case so no path leaves it unassigned (no latch).
   always_comb begin
      WrGate = 1'b0;
      case (state)
         RUN:     WrGate = !(Ack || (LoadInst && HAS_STALL));
         LWAIT:   WrGate = (stall_cnt == 3'd0);
         default: WrGate = 1'b0;
      endcase
   end

   assign Busy = (state == RUN) || (state == LWAIT);
   assign Done = (state == HALT);

`ifdef SEQ_CYCLE_COUNT_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         CycleCount <= 32'd0;
      end else if (!Busy && Start) begin
         CycleCount <= 32'd0;
      end else if (Busy && (CycleCount != 32'hFFFF_FFFF)) begin
         CycleCount <= CycleCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer (LOAD_STALL=2): directed program traces with a queued
// expectation per cycle, compared at the falling edge.
module tb_prog_sequencer;

   logic       Clk = 1'b0;
   logic       Reset, Start, Ack, ConditionalJump, BranchAbsOrRel, BranchTaken, LoadInst;
   logic [9:0] BranchTarget;
   logic [7:0] BranchOffset;
   logic [9:0] ProgCtr;
   logic       WrGate, Busy, Done;
`ifdef SEQ_CYCLE_COUNT_EN
   logic [31:0] CycleCount;
`endif

   prog_sequencer #(.PC_W(10), .OFF_W(8), .START_ADDR(0), .LOAD_STALL(2)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
      .ConditionalJump(ConditionalJump), .BranchAbsOrRel(BranchAbsOrRel),
      .BranchTaken(BranchTaken), .LoadInst(LoadInst),
      .BranchTarget(BranchTarget), .BranchOffset(BranchOffset),
      .ProgCtr(ProgCtr), .WrGate(WrGate), .Busy(Busy), .Done(Done)
`ifdef SEQ_CYCLE_COUNT_EN
      , .CycleCount(CycleCount)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [9:0]  pc;
      logic        wr;
      logic        busy;
      logic        done;
      logic [31:0] cc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          step  = 0;
   logic [31:0] exp_cc = 32'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs expected during that cycle, compare mid-cycle.
   task automatic cyc(input logic rst, st, ack, cj, rel, tk, ld,
                      input logic [9:0] tgt, input logic [7:0] off,
                      input logic [9:0] epc, input logic ewr, ebusy, edone);
      exp_t e, o;
      Reset = rst; Start = st; Ack = ack; ConditionalJump = cj; BranchAbsOrRel = rel;
      BranchTaken = tk; LoadInst = ld; BranchTarget = tgt; BranchOffset = off;
      e.pc = epc; e.wr = ewr; e.busy = ebusy; e.done = edone; e.cc = exp_cc;
      exp_q.push_back(e);
      @(negedge Clk);
      o = exp_q.pop_front();
      check($sformatf("pc@%0d", step),   32'(ProgCtr), 32'(o.pc));
      check($sformatf("wr@%0d", step),   32'(WrGate),  32'(o.wr));
      check($sformatf("busy@%0d", step), 32'(Busy),    32'(o.busy));
      check($sformatf("done@%0d", step), 32'(Done),    32'(o.done));
`ifdef SEQ_CYCLE_COUNT_EN
      check($sformatf("cc@%0d", step), CycleCount, o.cc);
`endif
      // Counter expectation for the next cycle, derived from the expected state flags.
      if (rst)                exp_cc = 32'd0;
      else if (!ebusy && st)  exp_cc = 32'd0;
      else if (ebusy)         exp_cc = exp_cc + 32'd1;
      step++;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Ack = 1'b0; ConditionalJump = 1'b0; BranchAbsOrRel = 1'b0;
      BranchTaken = 1'b0; LoadInst = 1'b0; BranchTarget = '0; BranchOffset = '0;
      @(posedge Clk);
      #1;
      //  rst st ack cj rel tk ld  tgt   off     pc   wr busy done
      cyc(1, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  0, 0, 0);  // reset state
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  0, 0, 0);  // Start accepted in IDLE
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  1, 1, 0);  // five plain instructions
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd1,  1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd2,  1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd3,  1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd4,  1, 1, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 10'd0, 8'h00,  10'd5,  0, 1, 0);  // halt instruction
      cyc(0, 0, 0, 1, 0, 1, 1, 10'd9, 8'h00,  10'd5,  0, 0, 1);  // HALT ignores decoder
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd5,  0, 0, 1);
      cyc(0, 1, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd5,  0, 0, 1);  // restart from HALT
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd1,  1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd2,  1, 1, 0);
      cyc(0, 0, 0, 1, 0, 1, 0, 10'd40, 8'h05, 10'd3,  1, 1, 0);  // absolute branch taken
      cyc(0, 0, 0, 1, 0, 0, 0, 10'd100, 8'h00, 10'd40, 1, 1, 0); // branch not taken
      cyc(0, 0, 1, 0, 0, 0, 0, 10'd0, 8'h00,  10'd41, 0, 1, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd41, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd1,  1, 1, 0);
      cyc(0, 0, 0, 1, 1, 1, 0, 10'd77, 8'hFD, 10'd2,  1, 1, 0);  // relative -3 wraps
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd1023, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  1, 1, 0);  // sequential wrap
      cyc(0, 0, 0, 1, 1, 1, 0, 10'd0, 8'h05,  10'd1,  1, 1, 0);  // relative +5
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd6,  1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 10'd0, 8'h00,  10'd7,  0, 1, 0);  // load at 7
      cyc(0, 0, 1, 1, 0, 1, 0, 10'd200, 8'h00, 10'd7, 0, 1, 0);  // LWAIT ignores strobes
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd7,  1, 1, 0);  // load writes now
      cyc(0, 1, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd8,  1, 1, 0);  // Start ignored in RUN
      cyc(0, 0, 0, 0, 0, 0, 1, 10'd0, 8'h00,  10'd9,  0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd9,  0, 1, 0);  // reset during LWAIT
      cyc(0, 0, 1, 1, 0, 1, 0, 10'd33, 8'h00, 10'd0,  0, 0, 0);  // IDLE ignores decoder
      cyc(0, 1, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  0, 0, 0);
      cyc(0, 0, 1, 1, 0, 1, 0, 10'd50, 8'h00, 10'd0,  0, 1, 0);  // Ack beats branch
      cyc(0, 1, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd1,  1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd2,  1, 1, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 10'd40, 8'h00, 10'd3,  1, 1, 0);  // branch at 3 not taken
      cyc(0, 0, 0, 1, 0, 1, 1, 10'd300, 8'h00, 10'd4, 0, 1, 0);  // load beats branch
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd4,  0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd4,  1, 1, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 10'd0, 8'h00,  10'd5,  0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd5,  0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd5,  0, 0, 1);  // reset from HALT
      cyc(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'h00,  10'd0,  0, 0, 0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
